// File: rtl/phy_mgmt_pkg.sv
// phy_mgmt_pkg: shared states, MDIO constants and frame helpers; POLL_XFER exists only with PHY_MGMT_LINK_POLL_EN
package phy_mgmt_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        INIT,
        IDLE,
        HOST_XFER
`ifdef PHY_MGMT_LINK_POLL_EN
        , POLL_XFER
`endif
    } state_e;

    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] ST        = 2'b01;
    localparam logic [4:0] REG_BMCR  = 5'd0;
    localparam logic [4:0] REG_BMSR  = 5'd1;
    localparam int         BMSR_LINK = 2;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Read frames carry ones after REGAD so the released line idles high
    function automatic logic [63:0] mdio_frame(logic wr, logic [4:0] phy, logic [4:0] ra, logic [15:0] d);
        return {32'hFFFF_FFFF, ST, wr ? OP_WRITE : OP_READ, phy, ra, wr ? 2'b10 : 2'b11, wr ? d : 16'hFFFF};
    endfunction

endpackage

// File: rtl/phy_mgmt_if.sv
// phy_mgmt_if: host register-access request/response port
interface phy_mgmt_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    modport master (output req_valid, req_write, req_reg, req_wdata, input req_ready, rsp_valid, rsp_rdata);
    modport slave  (input req_valid, req_write, req_reg, req_wdata, output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/phy_mgmt_mdio_master.sv
// mdio_master: MDC divider and 64-bit Clause-22 frame shifter with start/busy/done handshake
module mdio_master
    import phy_mgmt_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd0,
    parameter int         MDC_DIV  = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        write_i,
    input  logic [4:0]  reg_i,
    input  logic [15:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        mdc_o,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o
);
    localparam int DW = $clog2(MDC_DIV) + 1;

    logic          busy_q, mdc_q, oe_q, rd_op_q, tick;
    logic [DW-1:0] div_q;
    logic [5:0]    bit_q;
    logic [63:0]   sh_q;
    logic [15:0]   rdata_q;

    assign tick      = busy_q && div_q == DW'(MDC_DIV - 1);
    assign done_o    = tick && mdc_q && bit_q == 6'd63;
    assign busy_o    = busy_q;
    assign rdata_o   = rdata_q;
    assign mdc_o     = mdc_q;
    assign mdio_o    = sh_q[63];
    assign mdio_oe_o = oe_q;

    // Half-period divider; sample on MDC rise, shift the next bit out on MDC fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            mdc_q   <= 1'b0;
            oe_q    <= 1'b0;
            rd_op_q <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '1;
            rdata_q <= '0;
        end else if (!busy_q) begin
            if (start_i) begin
                busy_q  <= 1'b1;
                div_q   <= '0;
                bit_q   <= '0;
                oe_q    <= 1'b1;
                rd_op_q <= !write_i;
                sh_q    <= mdio_frame(write_i, PHY_ADDR, reg_i, wdata_i);
            end
        end else if (tick) begin
            div_q <= '0;
            mdc_q <= !mdc_q;
            if (!mdc_q) begin
                rdata_q <= {rdata_q[14:0], mdio_i};
            end else if (bit_q == 6'd63) begin
                busy_q <= 1'b0;
                oe_q   <= 1'b0;
                sh_q   <= '1;
            end else begin
                bit_q <= bit_q + 1'b1;
                sh_q  <= {sh_q[62:0], 1'b1};
                oe_q  <= !(rd_op_q && bit_q >= 6'd45);
            end
        end else begin
            div_q <= div_q + 1'b1;
        end
    end
endmodule

// File: rtl/phy_mgmt_ctrl.sv
// phy_mgmt_ctrl: PHY reset sequencing, BMCR init and host/poll MDIO arbitration; link polling with PHY_MGMT_LINK_POLL_EN
module phy_mgmt_ctrl
    import phy_mgmt_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR          = 5'd0,
    parameter int          MDC_DIV           = 25,
    parameter int          RESET_CYCLES      = 1_250_000,
    parameter int          POST_RESET_CYCLES = 625_000,
    parameter logic [15:0] INIT_BMCR         = 16'h1140,
    parameter int          POLL_CYCLES       = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       phy_reset_n,
    output logic       mdc,
    input  logic       mdio_i,
    output logic       mdio_o,
    output logic       mdio_oe,
    output logic       init_done,
    output logic       link_up,
    phy_mgmt_if.slave  host
);
    localparam int CW = $clog2(max3(RESET_CYCLES, POST_RESET_CYCLES, POLL_CYCLES)) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phy_q, init_q, rsp_valid_q, wr_q;
    logic [4:0]    reg_q, m_reg;
    logic [15:0]   wdata_q, rsp_rdata_q, m_wdata, m_rdata;
    logic          m_write, start, busy, done, accept;

`ifdef PHY_MGMT_LINK_POLL_EN
    logic [CW-1:0] ptmr_q;
    logic          link_q;
`endif

    assign accept         = host.req_valid && host.req_ready;
    assign host.req_ready = state_q == IDLE && !rsp_valid_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign phy_reset_n    = phy_q;
    assign init_done      = init_q;

    // Next state, phase timer and which frame the MDIO master is asked to send
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        m_write = 1'b1;
        m_reg   = REG_BMCR;
        m_wdata = INIT_BMCR;
        case (state_q)
            RST_HOLD: begin
                state_d = (cnt_q == CW'(RESET_CYCLES - 1)) ? RST_WAIT : RST_HOLD;
                cnt_d   = (cnt_q == CW'(RESET_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
            end
            RST_WAIT: begin
                state_d = (cnt_q == CW'(POST_RESET_CYCLES - 1)) ? INIT : RST_WAIT;
                cnt_d   = (cnt_q == CW'(POST_RESET_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
            end
            INIT: begin
                start   = !busy;
                state_d = done ? IDLE : INIT;
            end
            IDLE: begin
                if (accept) state_d = HOST_XFER;
`ifdef PHY_MGMT_LINK_POLL_EN
                else if (ptmr_q == CW'(POLL_CYCLES)) state_d = POLL_XFER;
`endif
            end
            HOST_XFER: begin
                start   = !busy;
                m_write = wr_q;
                m_reg   = reg_q;
                m_wdata = wdata_q;
                state_d = done ? IDLE : HOST_XFER;
            end
`ifdef PHY_MGMT_LINK_POLL_EN
            POLL_XFER: begin
                start   = !busy;
                m_write = 1'b0;
                m_reg   = REG_BMSR;
                state_d = done ? IDLE : POLL_XFER;
            end
`endif
            default: state_d = RST_HOLD;
        endcase
    end

    // State, PHY reset pin, captured host request and host response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            phy_q       <= 1'b0;
            init_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            reg_q       <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_q       <= state_d != RST_HOLD;
            init_q      <= init_q || (state_q == INIT && done);
            rsp_valid_q <= state_q == HOST_XFER && done;
            if (state_q == HOST_XFER && done) rsp_rdata_q <= wr_q ? '0 : m_rdata;
            if (accept) begin
                wr_q    <= host.req_write;
                reg_q   <= host.req_reg;
                wdata_q <= host.req_wdata;
            end
        end
    end

`ifdef PHY_MGMT_LINK_POLL_EN
    // Poll interval timer, restarted when a poll frame is issued, and latest BMSR link bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptmr_q <= '0;
            link_q <= 1'b0;
        end else begin
            ptmr_q <= (state_q == IDLE && state_d == POLL_XFER) ? '0 :
                      (state_q inside {IDLE, HOST_XFER, POLL_XFER} && ptmr_q != CW'(POLL_CYCLES)) ? ptmr_q + 1'b1 : ptmr_q;
            if (state_q == POLL_XFER && done) link_q <= m_rdata[BMSR_LINK];
        end
    end
    assign link_up = link_q;
`else
    assign link_up = 1'b0;
`endif

    mdio_master #(.PHY_ADDR(PHY_ADDR), .MDC_DIV(MDC_DIV)) u_mdio (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .write_i  (m_write),
        .reg_i    (m_reg),
        .wdata_i  (m_wdata),
        .busy_o   (busy),
        .done_o   (done),
        .rdata_o  (m_rdata),
        .mdc_o    (mdc),
        .mdio_i   (mdio_i),
        .mdio_o   (mdio_o),
        .mdio_oe_o(mdio_oe)
    );
endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// tb_phy_mgmt_ctrl: directed bench with an MDIO PHY model; poll checks compile in with PHY_MGMT_LINK_POLL_EN
module tb_phy_mgmt_ctrl;
    localparam int DIV  = 2;
    localparam int RST  = 20;
    localparam int POST = 10;
    localparam int POLL = 300;
    localparam int LAT  = 1 + 128 * DIV;

    logic clk = 1'b0;
    logic rst_n, phy_reset_n, mdc, mdio_i, mdio_o, mdio_oe, init_done, link_up;
    phy_mgmt_if hif();

    phy_mgmt_ctrl #(
        .PHY_ADDR(5'd0), .MDC_DIV(DIV), .RESET_CYCLES(RST), .POST_RESET_CYCLES(POST),
        .INIT_BMCR(16'h1140), .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .phy_reset_n(phy_reset_n), .mdc(mdc), .mdio_i(mdio_i),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .init_done(init_done), .link_up(link_up), .host(hif)
    );

    always #4 clk = ~clk;

    int          total = 0, bad = 0, nframes = 0, nrsp = 0, k = 0;
    logic [63:0] cap, last_frame;
    logic [1:0]  op_m;
    logic [4:0]  reg_m;
    logic        oe_bad;
    logic [15:0] bmsr = 16'h796D;
    logic [15:0] rdv;

    // PHY model: decode each MDC rise, check output enable, answer reads
    always @(posedge mdc or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            mdio_i = 1'b1;
        end else begin
            if (k == 0) oe_bad = 1'b0;
            cap = {cap[62:0], mdio_o};
            if (k == 35) op_m = cap[1:0];
            if (k == 45) reg_m = cap[4:0];
            if (k < 36 && mdio_oe !== 1'b1) oe_bad = 1'b1;
            if (k >= 36 && mdio_oe !== !(op_m == 2'b10 && k >= 46)) oe_bad = 1'b1;
            rdv = (reg_m == 5'd1) ? bmsr : (reg_m == 5'd2) ? 16'hBEEF : 16'h0000;
            mdio_i = (k >= 47 && k <= 62) ? rdv[62-k] : (k == 46) ? 1'b0 : 1'b1;
            if (k == 63) begin
                last_frame = cap;
                nframes++;
                k = 0;
            end else begin
                k++;
            end
        end
    end

    always @(negedge clk) if (hif.rsp_valid === 1'b1) nrsp++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host(input logic w, input logic [4:0] r, input logic [15:0] d, output int lat);
        logic rdy;
        hif.req_valid = 1'b1;
        hif.req_write = w;
        hif.req_reg   = r;
        hif.req_wdata = d;
        for (int i = 0; i < 2000; i++) begin
            rdy = hif.req_ready;
            @(posedge clk);
            if (rdy) break;
        end
        #1 hif.req_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 2000 && !hif.rsp_valid; i++) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    int n, lat, f0, n0;

    initial begin
        rst_n = 1'b0;
        hif.req_valid = 1'b0;
        hif.req_write = 1'b0;
        hif.req_reg   = 5'd0;
        hif.req_wdata = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pins", {phy_reset_n, mdc, mdio_o, mdio_oe}, 4'b0010);
        chk("rst_host", {hif.req_ready, hif.rsp_valid, hif.rsp_rdata}, 18'h0);
        chk("rst_status", {init_done, link_up}, 2'b00);

        @(negedge clk) rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 1000 && !phy_reset_n; i++) begin @(posedge clk); n++; #1; end
        chk("rst_hold_len", n, RST);
        n = 0;
        for (int i = 0; i < 1000 && !mdc; i++) begin @(posedge clk); n++; #1; end
        chk("first_mdc", n, POST + 1 + DIV);
        for (int i = 0; i < 1000 && !init_done; i++) begin @(posedge clk); #1; end
        chk("init_done", init_done, 1'b1);
        chk("init_frame", last_frame, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd0, 5'd0, 2'b10, 16'h1140});
        chk("init_frames", nframes, 1);
        chk("init_bus_idle", {mdc, mdio_oe, hif.req_ready, hif.rsp_valid}, 4'b0010);

        host(1'b0, 5'd2, 16'h0, lat);
        chk("rd_lat", lat, LAT);
        chk("rd_data", hif.rsp_rdata, 16'hBEEF);
        chk("rd_oe", oe_bad, 1'b0);
        chk("rd_hdr", last_frame[63:18], {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd2});
        chk("rd_ready_low", hif.req_ready, 1'b0);
        @(posedge clk); #1;
        chk("rd_pulse", {hif.rsp_valid, hif.req_ready}, 2'b01);

        host(1'b1, 5'd4, 16'h01E1, lat);
        chk("wr_lat", lat, LAT);
        chk("wr_rdata", hif.rsp_rdata, 16'h0);
        chk("wr_oe", oe_bad, 1'b0);
        chk("wr_frame", last_frame, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd0, 5'd4, 2'b10, 16'h01E1});
        @(posedge clk); #1;
        chk("rsp_count", nrsp, 2);

`ifdef PHY_MGMT_LINK_POLL_EN
        n0 = nrsp;
        for (int i = 0; i < 2000 && !link_up; i++) begin @(posedge clk); #1; end
        chk("link_up1", link_up, 1'b1);
        chk("poll_hdr", last_frame[63:18], {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd1});
        bmsr = 16'h7969;
        for (int i = 0; i < 2000 && link_up; i++) begin @(posedge clk); #1; end
        chk("link_down", link_up, 1'b0);
        chk("poll_no_rsp", nrsp, n0);

        bmsr = 16'h796D;
        for (int i = 0; i < 2000 && !mdio_oe; i++) begin @(posedge clk); #1; end
        repeat (POLL - 1) @(posedge clk);
        #1;
        f0 = nframes;
        host(1'b0, 5'd2, 16'h0, lat);
        chk("cont_host_first", nframes, f0 + 1);
        chk("cont_host_hdr", last_frame[63:18], {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd2});
        chk("cont_link_up", link_up, 1'b1);
        n = 0;
        for (int i = 0; i < 10 && !mdio_oe; i++) begin @(posedge clk); n++; #1; end
        chk("cont_poll_start", n, 2);
        for (int i = 0; i < 2000 && nframes < f0 + 2; i++) begin @(posedge clk); #1; end
        chk("cont_poll_hdr", last_frame[63:18], {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd1});
`else
        chk("no_link", link_up, 1'b0);
        f0 = nframes;
        repeat (400) @(posedge clk);
        #1;
        chk("no_poll", nframes, f0);
`endif

        hif.req_valid = 1'b1;
        hif.req_write = 1'b0;
        hif.req_reg   = 5'd2;
        for (int i = 0; i < 1000 && !hif.req_ready; i++) begin @(posedge clk); #1; end
        @(posedge clk);
        #1 hif.req_valid = 1'b0;
        for (int i = 0; i < 100 && !mdc; i++) begin @(posedge clk); #1; end
        chk("mid_frame", {mdc, mdio_oe}, 2'b11);
        f0 = nframes;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pins", {phy_reset_n, mdc, mdio_o, mdio_oe}, 4'b0010);
        chk("arst_host", {hif.req_ready, hif.rsp_valid, hif.rsp_rdata}, 18'h0);
        chk("arst_status", {init_done, link_up}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 1000 && !phy_reset_n; i++) begin @(posedge clk); n++; #1; end
        chk("rst2_hold_len", n, RST);
        for (int i = 0; i < 1000 && !init_done; i++) begin @(posedge clk); #1; end
        chk("rst2_init_frames", nframes, f0 + 1);
        chk("rst2_init_frame", last_frame, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd0, 5'd0, 2'b10, 16'h1140});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
